// File: rtl/dshot_pkg.sv
// Shared types and helpers for the DSHOT frame generator: mode encodings,
// FSM states, per-mode bit timing and the 4-bit frame checksum.
package dshot_pkg;

    localparam logic [15:0] MODE_VAL_150 = 16'd150;
    localparam logic [15:0] MODE_VAL_300 = 16'd300;
    localparam logic [15:0] MODE_VAL_600 = 16'd600;

    typedef enum logic [1:0] {MODE_150, MODE_300, MODE_600} mode_e;
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GUARD} state_e;

    typedef struct packed {
        logic [31:0] period;
        logic [31:0] t0h;
        logic [31:0] t1h;
    } timing_t;

    // Unsupported mode words fall back to DSHOT150.
    function automatic mode_e decode_mode(input logic [15:0] m);
        case (m)
            MODE_VAL_150: return MODE_150;
            MODE_VAL_300: return MODE_300;
            MODE_VAL_600: return MODE_600;
            default:      return MODE_150;
        endcase
    endfunction

    function automatic timing_t dshot_timing(input int unsigned clk_hz, input mode_e mode);
        timing_t     t;
        int unsigned bit_hz;
        case (mode)
            MODE_300: bit_hz = 300_000;
            MODE_600: bit_hz = 600_000;
            default:  bit_hz = 150_000;
        endcase
        t.period = clk_hz / bit_hz;
        t.t0h    = t.period * 32'd3 / 32'd8;
        t.t1h    = t.period * 32'd3 / 32'd4;
        return t;
    endfunction

    function automatic logic [15:0] dshot_apply_crc(input logic [15:0] v);
        return {v[15:4], v[15:12] ^ v[11:8] ^ v[7:4]};
    endfunction

endpackage

// File: rtl/dshot_multi_output_bit_timer.sv
// Bit/guard timebase: counts clocks within a bit period, bits within a frame
// and bit periods within the inter-frame guard.
module dshot_bit_timer #(
    parameter int unsigned CNT_W      = 9,
    parameter int unsigned GUARD_BITS = 4,
    localparam int unsigned GW        = $clog2(GUARD_BITS + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_send,
    input  logic             i_guard,
    input  logic [CNT_W-1:0] i_period,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_bit_strobe_c,
    output logic             o_frame_end_c,
    output logic             o_guard_end_c
);

    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bit_idx;
    logic [GW-1:0]    r_guard_idx;
    logic             w_wrap;

    assign w_wrap         = (r_cnt == i_period - CNT_W'(1));
    assign o_bit_strobe_c = (i_send | i_guard) & w_wrap;
    assign o_frame_end_c  = i_send & w_wrap & (r_bit_idx == 4'd0);
    assign o_guard_end_c  = i_guard & w_wrap & (r_guard_idx == GW'(GUARD_BITS - 1));
    assign o_cnt          = r_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt       <= '0;
            r_bit_idx   <= 4'd15;
            r_guard_idx <= '0;
        end else if (i_start) begin
            r_cnt       <= '0;
            r_bit_idx   <= 4'd15;
            r_guard_idx <= '0;
        end else if (o_bit_strobe_c) begin
            r_cnt <= '0;
            if (i_send) r_bit_idx <= r_bit_idx - 4'd1;
            if (i_guard) r_guard_idx <= o_guard_end_c ? '0 : r_guard_idx + GW'(1);
        end else if (i_send | i_guard) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dshot_multi_output.sv
// N-channel DSHOT generator: per-channel shadows launched together on commit.
// Optional DSHOT_AUTO_CRC_EN replaces the low nibble with the computed checksum.
module dshot_multi_output
    import dshot_pkg::*;
#(
    parameter int unsigned clockFrequency = 72_000_000,
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned GUARD_BITS     = 4,
    localparam int unsigned CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [15:0]         i_dshot_mode,
    input  logic [CH_W-1:0]     i_channel,
    input  logic [15:0]         i_dshot_value,
    input  logic                i_write,
    input  logic                i_commit,
    output logic [CHANNELS-1:0] o_pwm,
    output logic                o_ready,
    output logic                o_frame_done
);

    localparam timing_t     T150  = dshot_timing(clockFrequency, MODE_150);
    localparam timing_t     T300  = dshot_timing(clockFrequency, MODE_300);
    localparam timing_t     T600  = dshot_timing(clockFrequency, MODE_600);
    localparam int unsigned CNT_W = $clog2(T150.period + 1);

    state_e              r_state, w_state_next;
    mode_e               r_mode;
    logic                r_pending, w_pending_next, w_launch;
    logic [CHANNELS-1:0] r_pwm;
    logic                r_ready, r_frame_done;
    logic [15:0]         r_shadow [CHANNELS];
    logic [15:0]         r_shift  [CHANNELS];
    logic [15:0]         w_snap   [CHANNELS];
    logic [CNT_W-1:0]    w_period, w_t0h, w_t1h, w_cnt;
    logic                w_bit_strobe, w_frame_end, w_guard_end;

    dshot_bit_timer #(.CNT_W(CNT_W), .GUARD_BITS(GUARD_BITS)) u_timer (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_start        (w_launch),
        .i_send         (r_state == ST_SEND),
        .i_guard        (r_state == ST_GUARD),
        .i_period       (w_period),
        .o_cnt          (w_cnt),
        .o_bit_strobe_c (w_bit_strobe),
        .o_frame_end_c  (w_frame_end),
        .o_guard_end_c  (w_guard_end)
    );

    always_comb begin
        w_period = CNT_W'(T150.period);
        w_t0h    = CNT_W'(T150.t0h);
        w_t1h    = CNT_W'(T150.t1h);
        case (r_mode)
            MODE_300: begin
                w_period = CNT_W'(T300.period);
                w_t0h    = CNT_W'(T300.t0h);
                w_t1h    = CNT_W'(T300.t1h);
            end
            MODE_600: begin
                w_period = CNT_W'(T600.period);
                w_t0h    = CNT_W'(T600.t0h);
                w_t1h    = CNT_W'(T600.t1h);
            end
            default: ;
        endcase
    end

    // Snapshot bypasses a same-cycle write so it lands in the launched frame.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_snap[c] = (i_write && i_channel == CH_W'(c)) ? i_dshot_value : r_shadow[c];
`ifdef DSHOT_AUTO_CRC_EN
            w_snap[c] = dshot_apply_crc(w_snap[c]);
`endif
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pending) begin
                    w_state_next = ST_SEND;
                    w_launch     = 1'b1;
                end
            end
            ST_SEND: begin
                if (w_frame_end) w_state_next = ST_GUARD;
            end
            ST_GUARD: begin
                if (w_guard_end) begin
                    w_state_next = r_pending ? ST_SEND : ST_IDLE;
                    w_launch     = r_pending;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        w_pending_next = i_commit | (r_pending & ~w_launch);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_mode       <= MODE_150;
            r_pending    <= 1'b0;
            r_pwm        <= '0;
            r_ready      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pending    <= w_pending_next;
            r_ready      <= (w_state_next == ST_IDLE) && !w_pending_next;
            r_frame_done <= w_guard_end;
            if (w_launch) r_mode <= decode_mode(i_dshot_mode);
            for (int c = 0; c < CHANNELS; c++) begin
                r_pwm[c] <= (r_state == ST_SEND) && (w_cnt < (r_shift[c][15] ? w_t1h : w_t0h));
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_shadow[c] <= '0;
                r_shift[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (i_write && i_channel == CH_W'(c)) r_shadow[c] <= i_dshot_value;
                if (w_launch) r_shift[c] <= w_snap[c];
                else if (w_bit_strobe && r_state == ST_SEND) r_shift[c] <= {r_shift[c][14:0], 1'b0};
            end
        end
    end

    assign o_pwm        = r_pwm;
    assign o_ready      = r_ready;
    assign o_frame_done = r_frame_done;

endmodule
